hms_time_keeper: RTL
====================

Name: hms_time_keeper

Overview:
- Downstream consumer of the 4-bit enable-gated tick counter.
- Takes that counter's one-cycle terminal-count pulse as `tick_in` and keeps wall-clock time in BCD: hours 00-23, minutes 00-59, seconds 00-59.
- Provides a valid/ready load port for setting the time, with BCD range checking.
- Outputs feed the display/scan stage.

Parameters:
- TICKS_PER_SEC, 16, number of accepted tick_in pulses per second; legal range 1..65535.
- PRE_W, 16, width of the internal tick prescaler; must satisfy 2^PRE_W >= TICKS_PER_SEC.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- tick_in  in  1  one-cycle pulse from the upstream counter.
- pause  in  1  when 1, tick_in is ignored and time is frozen.
- load_valid  in  1  a load request is present.
- load_ready  out  1  block can accept a load this cycle.
- load_hh  in  8  BCD hours to load.
- load_mm  in  8  BCD minutes to load.
- load_ss  in  8  BCD seconds to load.
- load_done  out  1  one-cycle pulse: the load was committed.
- load_err  out  1  one-cycle pulse: the load was rejected (bad BCD or out of range).
- hh  out  8  BCD hours.
- mm  out  8  BCD minutes.
- ss  out  8  BCD seconds.
- sec_pulse  out  1  one-cycle pulse on every seconds increment.
- day_wrap  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.

Behaviour:
- Reset (synchronous, active-high):
  - hh/mm/ss = 00:00:00; prescaler = 0; FSM = IDLE.
  - load_ready = 1 from the first cycle after reset deasserts.
  - load_done, load_err, sec_pulse, day_wrap = 0.
  - Reset mid-load aborts the load with no done or err pulse.
- Prescaler:
  - Counts tick_in pulses only when pause = 0.
  - On reaching TICKS_PER_SEC-1 with tick_in = 1: prescaler clears and a seconds increment occurs.
  - tick_in during pause is dropped; the prescaler holds its value.
- Increment chain (registered; outputs change 1 cycle after the qualifying tick_in):
  - ss increments. 59 -> 00 carries into mm; mm 59 -> 00 carries into hh; hh 23 -> 00 asserts day_wrap.
  - Each BCD digit pair: low digit 9 -> 0 carries into the high digit.
  - sec_pulse and day_wrap are registered and coincide with the updated hh/mm/ss.
- FSM, states IDLE and CHECK:
  - IDLE: load_ready = 1. load_valid & load_ready latches load_hh/mm/ss into a shadow register, then -> CHECK.
  - CHECK: load_ready = 0. Validates the shadow value:
    - every nibble <= 9;
    - hh <= 0x23, mm <= 0x59, ss <= 0x59.
  - If valid: the next edge writes the shadow value to hh/mm/ss, clears the prescaler, pulses load_done, -> IDLE.
  - If invalid: time is unchanged, load_err pulses, -> IDLE.
  - Minimum spacing between accepted loads is 2 cycles.
- Simultaneous events:
  - A tick completing a second during the CHECK cycle is discarded on commit (the loaded value wins, no sec_pulse).
  - The same tick is applied normally on reject.
  - A tick on the accept cycle (IDLE) is applied normally; the commit overwrites it next cycle.
- pause has no effect on loads.

Decomposition:
- Shared package `time_pkg`:
  - constants: SEC_MAX = 8'h59, MIN_MAX = 8'h59, HR_MAX = 8'h23.
  - FSM state typedef (IDLE, CHECK).
  - function `bcd_valid(byte, max)`.
- Sub-module `bcd_mod_counter`:
  - parameter MAX (BCD).
  - ports: clk, reset, inc, load, load_val, q[7:0], wrap.
  - Instantiated three times for seconds, minutes and hours.
- Prescaler and FSM live in the top.

Test Plan:
1. Reset, TICKS_PER_SEC=4, 8 tick_in pulses with pause=0 -> ss=0x02; sec_pulse pulses twice, each 1 cycle after the 4th and 8th tick.
2. Load 23:59:58, then 8 ticks -> ss reads 59, then 00:00:00; day_wrap pulses exactly once, in the same cycle as sec_pulse.
3. Load hh=0x24 -> load_err pulses in the cycle after CHECK; time unchanged. Load ss=0x5A -> load_err. Load 12:34:56 -> load_done; hh/mm/ss = 12:34:56.
4. pause=1 with 10 ticks -> no change; prescaler held. pause=0 resumes from the held prescaler count.
5. Load 01:02:03 with a second-completing tick in the CHECK cycle -> reads 01:02:03, no sec_pulse. Repeat with an invalid load -> the tick is applied: ss +1 and sec_pulse.
6. Assert reset during CHECK -> next cycle 00:00:00, no load_done/load_err, load_ready=1 once reset is released.

Source files
------------

// File: rtl/time_pkg.sv
// Shared constants, FSM state type and BCD range check for the HH:MM:SS time keeper.
package time_pkg;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  typedef enum logic {IDLE, CHECK} state_e;

  // Both nibbles must be decimal digits; for legal BCD a binary compare orders correctly.
  function automatic logic bcd_valid(input logic [7:0] b, input logic [7:0] max);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b <= max);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX; load takes priority over increment.
module bcd_mod_counter
  import time_pkg::*;
#(
  parameter logic [7:0] MAX = SEC_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] q,
  output logic       wrap
);

  logic [7:0] q_d;

  assign wrap = inc && !load && (q == MAX);

  always_comb begin
    q_d = q;
    if (load) begin
      q_d = load_val;
    end else if (inc) begin
      if (q == MAX) begin
        q_d = 8'h00;
      end else if (q[3:0] == 4'd9) begin
        q_d = {q[7:4] + 4'd1, 4'd0};
      end else begin
        q_d = {q[7:4], q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 8'h00;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/hms_time_keeper.sv
// BCD wall clock driven by an upstream tick pulse, with a checked valid/ready load port.
module hms_time_keeper
  import time_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 16,
  parameter int unsigned PRE_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       pause,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic       load_done,
  output logic       load_err,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_pulse,
  output logic       day_wrap
);

  localparam logic [PRE_W-1:0] PreLast = PRE_W'(TICKS_PER_SEC - 1);

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       sh_hh_q, sh_mm_q, sh_ss_q;
  logic             accept, shadow_ok, commit, reject;
  logic             tick_ok, sec_done, ss_inc;
  logic             ss_wrap, mm_wrap, hh_wrap;

  assign load_ready = (state_q == IDLE);
  assign accept     = load_ready && load_valid;
  assign shadow_ok  = bcd_valid(sh_hh_q, HR_MAX) && bcd_valid(sh_mm_q, MIN_MAX) &&
                      bcd_valid(sh_ss_q, SEC_MAX);
  assign commit     = (state_q == CHECK) && shadow_ok;
  assign reject     = (state_q == CHECK) && !shadow_ok;

  assign tick_ok  = tick_in && !pause;
  assign sec_done = tick_ok && (pre_q == PreLast);
  // A second completing on the commit cycle is swallowed: the loaded time wins.
  assign ss_inc   = sec_done && !commit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (load_valid) state_d = CHECK;
      CHECK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pre_d = pre_q;
    if (commit) begin
      pre_d = '0;
    end else if (tick_ok) begin
      pre_d = sec_done ? '0 : pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      sh_hh_q   <= 8'h00;
      sh_mm_q   <= 8'h00;
      sh_ss_q   <= 8'h00;
      sec_pulse <= 1'b0;
      day_wrap  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      sec_pulse <= ss_inc;
      day_wrap  <= hh_wrap;
      load_done <= commit;
      load_err  <= reject;
      if (accept) begin
        sh_hh_q <= load_hh;
        sh_mm_q <= load_mm;
        sh_ss_q <= load_ss;
      end
    end
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk      (clk),
    .reset    (reset),
    .inc      (ss_inc),
    .load     (commit),
    .load_val (sh_ss_q),
    .q        (ss),
    .wrap     (ss_wrap)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk      (clk),
    .reset    (reset),
    .inc      (ss_wrap),
    .load     (commit),
    .load_val (sh_mm_q),
    .q        (mm),
    .wrap     (mm_wrap)
  );

  bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
    .clk      (clk),
    .reset    (reset),
    .inc      (mm_wrap),
    .load     (commit),
    .load_val (sh_hh_q),
    .q        (hh),
    .wrap     (hh_wrap)
  );

endmodule
